// File: rtl/piano_note_scheduler.sv
// rtl/piano_note_scheduler.sv - timed note FIFO that plays 8-bit piano commands for programmed tick counts
// Each note is followed by a fixed silent gap; iStop flushes and silences.
module piano_note_scheduler #(
   parameter int CLK_HZ     = 100_000_000,
   parameter int TICK_HZ    = 1000,
   parameter int FIFO_DEPTH = 8,
   parameter int GAP_MS     = 20
) (
   input  logic                          iFpgaClock,
   input  logic                          iCpuReset,
   input  logic                          iCmdWrite,
   input  logic [23:0]                   iCmdData,
   input  logic                          iStop,
   output logic [7:0]                    oPianoCommand,
   output logic                          oPianoWrite,
   output logic                          oBusy,
   output logic                          oEmpty,
   output logic                          oFull,
   output logic [$clog2(FIFO_DEPTH):0]   oCount,
   output logic                          oOverflow
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int PW  = $clog2(DIV);

   localparam logic [PW-1:0] PRE_MAX  = PW'(DIV - 1);
   localparam logic [15:0]   GAP_LOAD = 16'(GAP_MS);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_PLAY = 2'd2;
   localparam logic [1:0] S_GAP  = 2'd3;

   logic [23:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_overflow;
   logic [1:0]    r_state;
   logic [PW-1:0] r_presc;
   logic [15:0]   r_remaining;
   logic [15:0]   r_gap;
   logic [23:0]   r_entry;
   logic [7:0]    r_cmd;
   logic          r_write;

   logic w_empty;
   logic w_full;
   logic w_tick;
   logic w_push;
   logic w_note_end;
   logic w_gap_done;
   logic w_pop;

   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == CNT_FULL);
   assign w_tick     = (r_presc == PRE_MAX);
   assign w_push     = iCmdWrite & ~w_full & ~iStop;
   assign w_note_end = (r_state == S_PLAY) & w_tick & (r_remaining == 16'd1);
   assign w_gap_done = (r_state == S_GAP) & (r_gap == 16'd0);
   // A pop only happens where the FSM is ready to accept the next entry.
   assign w_pop      = ~iStop & ~w_empty &
                       ((r_state == S_IDLE) | (w_note_end & (GAP_MS == 0)) | w_gap_done);

   always_ff @(posedge iFpgaClock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= iCmdData;
      end
   end

   always_ff @(posedge iFpgaClock or negedge iCpuReset) begin
      if (!iCpuReset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_state     <= S_IDLE;
         r_presc     <= '0;
         r_remaining <= '0;
         r_gap       <= '0;
         r_entry     <= '0;
         r_cmd       <= '0;
         r_write     <= 1'b0;
      end else begin
         r_write <= 1'b0;
         if (iStop) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_state     <= S_IDLE;
            r_presc     <= '0;
            r_remaining <= '0;
            r_gap       <= '0;
            r_cmd       <= '0;
            r_write     <= (r_cmd != 8'd0);
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (iCmdWrite && w_full) begin
               r_overflow <= 1'b1;
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + AW'(1);
               r_entry  <= r_mem[r_rd_ptr];
            end
            if (w_push && !w_pop) begin
               r_count <= r_count + CNT_ONE;
            end else if (!w_push && w_pop) begin
               r_count <= r_count - CNT_ONE;
            end

            r_presc <= w_tick ? '0 : r_presc + PW'(1);

            case (r_state)
               S_IDLE: begin
                  if (w_pop) begin
                     r_state <= S_LOAD;
                  end
               end
               S_LOAD: begin
                  if (r_entry[15:0] == 16'd0) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_cmd       <= r_entry[23:16];
                     r_write     <= 1'b1;
                     r_remaining <= r_entry[15:0];
                     r_presc     <= '0;
                     r_state     <= S_PLAY;
                  end
               end
               S_PLAY: begin
                  if (w_tick) begin
                     r_remaining <= r_remaining - 16'd1;
                  end
                  if (w_note_end) begin
                     if (GAP_MS > 0) begin
                        r_cmd   <= 8'd0;
                        r_write <= 1'b1;
                        r_gap   <= GAP_LOAD;
                        r_presc <= '0;
                        r_state <= S_GAP;
                     end else if (w_pop) begin
                        r_state <= S_LOAD;
                     end else begin
                        r_cmd   <= 8'd0;
                        r_write <= 1'b1;
                        r_state <= S_IDLE;
                     end
                  end
               end
               default: begin
                  // Gap counter sits at zero for one cycle while the exit decision is made.
                  if (w_gap_done) begin
                     r_state <= w_pop ? S_LOAD : S_IDLE;
                  end else if (w_tick) begin
                     r_gap <= r_gap - 16'd1;
                  end
               end
            endcase
         end
      end
   end

   assign oPianoCommand = r_cmd;
   assign oPianoWrite   = r_write;
   assign oBusy         = (r_state != S_IDLE);
   assign oEmpty        = w_empty;
   assign oFull         = w_full;
   assign oCount        = r_count;
   assign oOverflow     = r_overflow;

endmodule

// File: tb/tb_piano_note_scheduler.sv
// tb/tb_piano_note_scheduler.sv - scoreboard bench for piano_note_scheduler
module tb_piano_note_scheduler;

   localparam int DIV   = 10;
   localparam int DEPTH = 4;
   localparam int GAP   = 2;
   localparam int BIG   = 32'h3fff_ffff;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        wr = 1'b0;
   logic        stop = 1'b0;
   logic [23:0] data = '0;
   logic [7:0]  pcmd;
   logic        pw, busy, empty, full, ovf;
   logic [2:0]  cnt;

   piano_note_scheduler #(
      .CLK_HZ(1000), .TICK_HZ(100), .FIFO_DEPTH(DEPTH), .GAP_MS(GAP)
   ) dut (
      .iFpgaClock(clk), .iCpuReset(rst_n), .iCmdWrite(wr), .iCmdData(data), .iStop(stop),
      .oPianoCommand(pcmd), .oPianoWrite(pw), .oBusy(busy), .oEmpty(empty),
      .oFull(full), .oCount(cnt), .oOverflow(ovf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int e; logic [7:0] c; } exp_t;
   exp_t q[$];
   int   m_push[$];
   int   m_pop[$];
   int   m_avail = 0;
   int   m_ovf_edge = BIG;
   int   n_vec = 0;
   int   n_bad = 0;
   int   n_writes = 0;
   bit   chk_count = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (edge %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int model_count(input int e);
      int n = 0;
      foreach (m_push[i]) if (m_push[i] <= e && m_pop[i] > e) n++;
      return n;
   endfunction

   // Reference: one scheduler serving notes in order; a note is popped once it is
   // queued and the scheduler is free, plays dur*DIV cycles, then a GAP*DIV silence.
   task automatic model_add(input logic [7:0] c, input int dur, input int t);
      int occ = 0;
      int pop;
      foreach (m_pop[i]) if (m_pop[i] >= t) occ++;
      if (occ >= DEPTH) begin
         if (m_ovf_edge > t) m_ovf_edge = t;
         return;
      end
      pop = (t + 1 > m_avail) ? t + 1 : m_avail;
      if (dur == 0) begin
         m_avail = pop + 2;
      end else begin
         q.push_back('{pop + 1, c});
         q.push_back('{pop + 1 + dur * DIV, 8'h00});
         m_avail = pop + 1 + dur * DIV + GAP * DIV + 1;
      end
      m_push.push_back(t);
      m_pop.push_back(pop);
   endtask

   task automatic model_clear();
      m_push.delete();
      m_pop.delete();
      m_avail    = 0;
      m_ovf_edge = BIG;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic sched(input logic [7:0] c, input int dur);
      model_add(c, dur, cyc + 1);
      wr   = 1'b1;
      data = {c, 16'(dur)};
      step();
      wr   = 1'b0;
   endtask

   task automatic wait_done();
      while (cyc < m_avail + 4) step();
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (pw) begin
            n_writes++;
            if (q.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL unexpected_write: got cmd %0h at edge %0d, want none", pcmd, cyc);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("write_edge", cyc, e.e);
               chk("write_cmd", pcmd, e.c);
            end
         end
         if (chk_count) begin
            chk("count", cnt, model_count(cyc));
            chk("overflow", ovf, (cyc >= m_ovf_edge) ? 1 : 0);
         end
      end
   end

   initial begin
      int t, w0, first_pop;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_cmd", pcmd, 0);
      chk("rst_write", pw, 0);
      chk("rst_busy", busy, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_count", cnt, 0);
      chk("rst_ovf", ovf, 0);
      repeat (3) step();
      rst_n = 1'b1;
      chk_count = 1'b1;
      repeat (2) step();

      // single note
      sched(8'h15, 3);
      wait_done();
      chk("single_busy", busy, 0);
      chk("single_empty", empty, 1);

      // back-to-back notes
      w0 = n_writes;
      sched(8'h11, 1);
      sched(8'h12, 2);
      wait_done();
      chk("b2b_writes", n_writes - w0, 4);

      // zero duration entry is skipped
      sched(8'h20, 0);
      sched(8'h21, 1);
      wait_done();

      // full and overflow
      model_clear();
      sched(8'h15, 3);
      repeat (2) step();
      for (int i = 0; i < 4; i++) sched(8'(8'h40 + i), 1);
      chk("full_flag", full, 1);
      chk("full_count", cnt, 4);
      sched(8'h44, 1);
      chk("ovf_set", ovf, 1);
      chk("ovf_count", cnt, 4);
      first_pop = m_pop[1];
      while (cyc + 1 < first_pop) step();
      sched(8'h45, 1);
      chk("ovf_pushpop_ovf", ovf, 1);
      chk("ovf_pushpop_count", cnt, 3);
      wait_done();

      // stop mid-note with a concurrent push
      chk_count = 1'b0;
      model_clear();
      t = cyc + 1;
      sched(8'h15, 3);
      for (int i = 0; i < 5; i++) sched(8'(8'h50 + i), 2);
      while (cyc + 1 < t + 12) step();
      q.delete();
      q.push_back('{cyc + 1, 8'h00});
      stop = 1'b1;
      wr   = 1'b1;
      data = {8'h77, 16'd5};
      step();
      stop = 1'b0;
      wr   = 1'b0;
      chk("stop_cmd", pcmd, 0);
      chk("stop_write", pw, 1);
      chk("stop_count", cnt, 0);
      chk("stop_ovf", ovf, 0);
      chk("stop_busy", busy, 0);
      model_clear();
      chk_count = 1'b1;
      repeat (40) step();

      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         sched(8'($urandom_range(0, 255)), $urandom_range(0, 3));
         repeat ($urandom_range(0, 35)) step();
      end
      wait_done();

      // asynchronous reset during the gap
      chk_count = 1'b0;
      model_clear();
      t = cyc + 1;
      sched(8'h33, 1);
      while (cyc < t + 20) step();
      chk("gap_busy", busy, 1);
      @(negedge clk);
      #1 rst_n = 1'b0;
      q.delete();
      #1;
      chk("arst_cmd", pcmd, 0);
      chk("arst_write", pw, 0);
      chk("arst_busy", busy, 0);
      chk("arst_empty", empty, 1);
      chk("arst_full", full, 0);
      chk("arst_count", cnt, 0);
      chk("arst_ovf", ovf, 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (30) step();
      chk("post_rst_empty", empty, 1);
      chk("post_rst_busy", busy, 0);

      chk("leftover_expected", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
